// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives a 1-cycle synchronous-read ROM
// and buffers returned words in a 2-entry queue presented to decode via valid/ready.
module imem_fetch_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] tag_q, tag_d;
    entry_t                head_q, head_d;
    entry_t                tail_q, tail_d;
    logic [1:0]            count_q, count_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occupancy;
    logic [1:0]            base;
    entry_t                ret;

    assign inst_valid = (count_q != 2'd0);
    assign inst       = head_q.data;
    assign inst_pc    = head_q.pc;
    assign mem_en     = issue;
    assign mem_addr   = fetch_pc_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        base       = count_q;
        ret        = '{data: mem_rdata, pc: tag_q};

        pop  = inst_valid && inst_ready;
        push = inflight_q && !redirect;

        // Words that will be held after this edge plus the read already in flight.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == S_RUN) && !redirect && (occupancy < 3'd2);

        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase

        if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            inflight_d = 1'b1;
            tag_d      = fetch_pc_q;
        end

        if (redirect) begin
            // Redirect squashes queued and in-flight words; a concurrent pop still completes.
            state_d    = S_FLUSH;
            fetch_pc_d = redirect_pc;
            count_d    = 2'd0;
        end else begin
            base = count_q - {1'b0, pop};
            if (pop) begin
                head_d = tail_q;
            end
            if (push) begin
                if (base == 2'd0) begin
                    head_d = ret;
                end else begin
                    tail_d = ret;
                end
            end
            count_d = base + {1'b0, push};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            // NOTE: queue storage is reset as well because inst/inst_pc must read zero out of reset.
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

endmodule
